anabellek_hakem: RTL and testbench

ANABELLEK_HAKEM -- requirements
Module: anabellek_hakem

---
 rtl/anabellek_hakem.sv | 162 ++++++++++++++++
 tb/tb_anabellek_hakem.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anabellek_hakem.sv
// anabellek_hakem: two-port round-robin arbiter in front of a single block
// memory. Exactly one memory transaction is in flight at any time; a read
// is returned to the port that issued it, a write completes silently.
//
// Handshake rule on every channel (port request, port response, memory
// request, memory response): a transfer takes place on the rising clk_i edge
// where the sender's valid (gecerli) and the receiver's ready (hazir) are both
// 1. The sender keeps valid and payload stable until that edge; the receiver
// may raise ready without waiting for valid.
module anabellek_hakem #(
    parameter int ADRES_W = 32,
    parameter int VERI_W  = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [2*ADRES_W-1:0] port_istek_adres_i,
    input  logic [2*VERI_W-1:0]  port_istek_veri_i,
    input  logic [1:0]           port_istek_gecerli_i,
    input  logic [1:0]           port_istek_yaz_i,
    output logic [1:0]           port_istek_hazir_o,
    output logic [VERI_W-1:0]    port_cevap_veri_o,
    output logic [1:0]           port_cevap_gecerli_o,
    input  logic [1:0]           port_cevap_hazir_i,

    output logic [ADRES_W-1:0]   anabellek_istek_adres_o,
    output logic [VERI_W-1:0]    anabellek_istek_veri_o,
    output logic                 anabellek_istek_gecerli_o,
    output logic                 anabellek_istek_yaz_gecerli_o,
    input  logic                 anabellek_istek_hazir_i,
    input  logic [VERI_W-1:0]    anabellek_cevap_veri_i,
    input  logic                 anabellek_cevap_gecerli_i,
    output logic                 anabellek_cevap_hazir_o,

    // Debug view of the controller state (BOS=0, ISTEK=1, CEVAP_BEKLE=2,
    // CEVAP_ILET=3).
    output logic [1:0]           durum_o
);

    typedef enum logic [1:0] {
        BOS         = 2'd0,
        ISTEK       = 2'd1,
        CEVAP_BEKLE = 2'd2,
        CEVAP_ILET  = 2'd3
    } durum_e;

    durum_e              durum_q, durum_d;
    logic                son_kazanan_q, son_kazanan_d;  // last granted port
    logic                sahip_q, sahip_d;              // owner of current transaction
    logic [ADRES_W-1:0]  adres_q, adres_d;
    logic [VERI_W-1:0]   veri_q, veri_d;
    logic                yaz_q, yaz_d;
    logic [VERI_W-1:0]   cevap_veri_q, cevap_veri_d;

    logic                kazanan;  // port that would win a grant this cycle
    logic [1:0]          izin;     // grant pulse, before reset gating

    // Round-robin pick: on a tie the port that did not win last time goes,
    // a lone requester always goes.
    always_comb begin
        if (port_istek_gecerli_i == 2'b11) begin
            kazanan = ~son_kazanan_q;
        end else begin
            kazanan = port_istek_gecerli_i[1];
        end
    end

    // Next-state and latch-enable logic of the transaction controller.
    always_comb begin
        durum_d       = durum_q;
        son_kazanan_d = son_kazanan_q;
        sahip_d       = sahip_q;
        adres_d       = adres_q;
        veri_d        = veri_q;
        yaz_d         = yaz_q;
        cevap_veri_d  = cevap_veri_q;
        izin          = 2'b00;

        case (durum_q)
            BOS: begin
                if (|port_istek_gecerli_i) begin
                    izin          = kazanan ? 2'b10 : 2'b01;
                    son_kazanan_d = kazanan;
                    sahip_d       = kazanan;
                    if (kazanan) begin
                        adres_d = port_istek_adres_i[2*ADRES_W-1:ADRES_W];
                        veri_d  = port_istek_veri_i[2*VERI_W-1:VERI_W];
                        yaz_d   = port_istek_yaz_i[1];
                    end else begin
                        adres_d = port_istek_adres_i[ADRES_W-1:0];
                        veri_d  = port_istek_veri_i[VERI_W-1:0];
                        yaz_d   = port_istek_yaz_i[0];
                    end
                    durum_d = ISTEK;
                end
            end

            ISTEK: begin
                // Writes carry no response, so they finish on acceptance.
                if (anabellek_istek_hazir_i) begin
                    durum_d = yaz_q ? BOS : CEVAP_BEKLE;
                end
            end

            CEVAP_BEKLE: begin
                if (anabellek_cevap_gecerli_i) begin
                    cevap_veri_d = anabellek_cevap_veri_i;
                    durum_d      = CEVAP_ILET;
                end
            end

            CEVAP_ILET: begin
                if (port_cevap_hazir_i[sahip_q]) begin
                    durum_d = BOS;
                end
            end

            default: begin
                durum_d = BOS;
            end
        endcase
    end

    // State and transaction registers; reset abandons any transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q       <= BOS;
            son_kazanan_q <= 1'b1;
            sahip_q       <= 1'b0;
            adres_q       <= '0;
            veri_q        <= '0;
            yaz_q         <= 1'b0;
            cevap_veri_q  <= '0;
        end else begin
            durum_q       <= durum_d;
            son_kazanan_q <= son_kazanan_d;
            sahip_q       <= sahip_d;
            adres_q       <= adres_d;
            veri_q        <= veri_d;
            yaz_q         <= yaz_d;
            cevap_veri_q  <= cevap_veri_d;
        end
    end

    // Output decode. The grant pulse is combinational on the request valids,
    // so it is masked by rst_i to keep every output quiet during reset.
    always_comb begin
        port_istek_hazir_o            = izin & {2{~rst_i}};
        anabellek_istek_gecerli_o     = (durum_q == ISTEK);
        anabellek_istek_yaz_gecerli_o = (durum_q == ISTEK) & yaz_q;
        anabellek_istek_adres_o       = adres_q;
        anabellek_istek_veri_o        = veri_q;
        anabellek_cevap_hazir_o       = (durum_q == CEVAP_BEKLE);
        port_cevap_veri_o             = cevap_veri_q;
        port_cevap_gecerli_o          = 2'b00;
        if (durum_q == CEVAP_ILET) begin
            port_cevap_gecerli_o = sahip_q ? 2'b10 : 2'b01;
        end
        durum_o = durum_q;
    end

endmodule

// File: tb/tb_anabellek_hakem.sv
// Bench for anabellek_hakem: directed scenarios followed by a randomized
// soak, all checked against a transaction-level model of the arbiter, a
// reference memory and a device-side memory written from the DUT bus.
module tb_anabellek_hakem;

    localparam int AW = 32;
    localparam int VW = 128;

    // Transaction phases of the reference model.
    localparam int PH_IDLE   = 0;  // no transaction owned
    localparam int PH_MEMREQ = 1;  // request offered to memory
    localparam int PH_MEMRSP = 2;  // read accepted, waiting for data
    localparam int PH_PORT   = 3;  // read data offered to the owner port

    // ---------------- clock / reset ----------------
    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [2*AW-1:0] port_istek_adres_i;
    logic [2*VW-1:0] port_istek_veri_i;
    logic [1:0]      port_istek_gecerli_i;
    logic [1:0]      port_istek_yaz_i;
    logic [1:0]      port_istek_hazir_o;
    logic [VW-1:0]   port_cevap_veri_o;
    logic [1:0]      port_cevap_gecerli_o;
    logic [1:0]      port_cevap_hazir_i;
    logic [AW-1:0]   anabellek_istek_adres_o;
    logic [VW-1:0]   anabellek_istek_veri_o;
    logic            anabellek_istek_gecerli_o;
    logic            anabellek_istek_yaz_gecerli_o;
    logic            anabellek_istek_hazir_i;
    logic [VW-1:0]   anabellek_cevap_veri_i;
    logic            anabellek_cevap_gecerli_i;
    logic            anabellek_cevap_hazir_o;
    logic [1:0]      durum_o;

    always #5 clk_i = ~clk_i;

    anabellek_hakem #(.ADRES_W(AW), .VERI_W(VW)) dut (
        .clk_i                         (clk_i),
        .rst_i                         (rst_i),
        .port_istek_adres_i            (port_istek_adres_i),
        .port_istek_veri_i             (port_istek_veri_i),
        .port_istek_gecerli_i          (port_istek_gecerli_i),
        .port_istek_yaz_i              (port_istek_yaz_i),
        .port_istek_hazir_o            (port_istek_hazir_o),
        .port_cevap_veri_o             (port_cevap_veri_o),
        .port_cevap_gecerli_o          (port_cevap_gecerli_o),
        .port_cevap_hazir_i            (port_cevap_hazir_i),
        .anabellek_istek_adres_o       (anabellek_istek_adres_o),
        .anabellek_istek_veri_o        (anabellek_istek_veri_o),
        .anabellek_istek_gecerli_o     (anabellek_istek_gecerli_o),
        .anabellek_istek_yaz_gecerli_o (anabellek_istek_yaz_gecerli_o),
        .anabellek_istek_hazir_i       (anabellek_istek_hazir_i),
        .anabellek_cevap_veri_i        (anabellek_cevap_veri_i),
        .anabellek_cevap_gecerli_i     (anabellek_cevap_gecerli_i),
        .anabellek_cevap_hazir_o       (anabellek_cevap_hazir_o),
        .durum_o                       (durum_o)
    );

    // ---------------- scoreboard / model state ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [1:0]    req_pend;
    logic [AW-1:0] req_adr [2];
    logic [VW-1:0] req_dat [2];
    logic          req_wr  [2];

    logic [VW-1:0] ref_mem [logic [AW-1:0]];  // written from requests at grant
    logic [VW-1:0] mem_dev [logic [AW-1:0]];  // written from the DUT memory bus
    logic [VW-1:0] exp_q [$];                 // expected read data, in order
    int            grant_log [$];             // granted port as seen on the DUT

    int            phase = PH_IDLE;
    logic          last_win = 1'b1;
    logic          cur_port;
    logic [AW-1:0] cur_adr;
    logic [VW-1:0] cur_dat;
    logic          cur_wr;
    logic [VW-1:0] exp_dlv;
    logic [AW-1:0] dev_rd_adr;
    logic [VW-1:0] last_rsp_dat;
    logic [1:0]    last_rsp_cg;
    int            resp_dly = 0;
    int            cyc = 0;
    int            grant_cyc = 0;
    int            model_grants = 0;
    bit            lat_chk = 1'b0;
    bit            first_dlv = 1'b0;

    // Stimulus knobs (percentages and response delay range).
    int            req_pct = 0;
    logic [1:0]    req_mask = 2'b11;
    int            acc_pct = 100;
    int            rdy_pct = 100;
    int            dly_min = 0;
    int            dly_max = 0;
    int            spur_pct = 0;
    int            wd_pct = 0;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] seed_val(input logic [AW-1:0] a);
        return {4{a ^ 32'h5EED_0000}};
    endfunction

    function automatic logic [VW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return seed_val(a);
    endfunction

    function automatic logic [VW-1:0] dev_rd(input logic [AW-1:0] a);
        if (mem_dev.exists(a)) return mem_dev[a];
        return seed_val(a);
    endfunction

    function automatic logic [VW-1:0] rnd_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_knobs(input int rq, input int ac, input int rd, input int dmin,
                             input int dmax, input int sp, input int wd);
        req_pct = rq; acc_pct = ac; rdy_pct = rd;
        dly_min = dmin; dly_max = dmax; spur_pct = sp; wd_pct = wd;
    endtask

    task automatic post_req(input int p, input logic [AW-1:0] a, input logic [VW-1:0] d, input logic w);
        req_pend[p] = 1'b1;
        req_adr[p]  = a;
        req_dat[p]  = d;
        req_wr[p]   = w;
    endtask

    task automatic clear_reqs();
        req_pend = 2'b00;
    endtask

    // Applies this cycle's inputs; called just after the rising edge.
    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (req_pend[p]) begin
                if ($urandom_range(0, 99) < wd_pct) req_pend[p] = 1'b0;
            end else if (req_mask[p] && $urandom_range(0, 99) < req_pct) begin
                post_req(p, AW'($urandom_range(0, 15)) << 4, rnd_blk(), 1'($urandom_range(0, 1)));
            end
        end
        port_istek_gecerli_i = req_pend;
        port_istek_adres_i   = {req_adr[1], req_adr[0]};
        port_istek_veri_i    = {req_dat[1], req_dat[0]};
        port_istek_yaz_i     = {req_wr[1], req_wr[0]};
        for (int p = 0; p < 2; p++) begin
            port_cevap_hazir_i[p] = ($urandom_range(0, 99) < rdy_pct);
        end
        anabellek_istek_hazir_i = ($urandom_range(0, 99) < acc_pct);
        if (phase == PH_MEMRSP) begin
            if (resp_dly == 0) begin
                anabellek_cevap_gecerli_i = 1'b1;
                anabellek_cevap_veri_i    = dev_rd(dev_rd_adr);
            end else begin
                resp_dly--;
                anabellek_cevap_gecerli_i = 1'b0;
                anabellek_cevap_veri_i    = rnd_blk();
            end
        end else begin
            // Stray memory responses while no read is outstanding.
            anabellek_cevap_gecerli_i = ($urandom_range(0, 99) < spur_pct);
            anabellek_cevap_veri_i    = rnd_blk();
        end
    endtask

    // Compares outputs with the model, then advances the model across the
    // coming rising edge. Called at the falling edge.
    task automatic observe();
        logic [1:0] exp_hz;
        logic [1:0] exp_cg;
        logic       w;
        exp_hz = 2'b00;
        w      = 1'b0;
        if (phase == PH_IDLE && req_pend != 2'b00) begin
            w      = (req_pend == 2'b11) ? ~last_win : req_pend[1];
            exp_hz = w ? 2'b10 : 2'b01;
        end
        check("istek_hazir", port_istek_hazir_o, exp_hz);
        if (port_istek_hazir_o != 2'b00) grant_log.push_back(int'(port_istek_hazir_o[1]));

        check("mem_gecerli", anabellek_istek_gecerli_o, phase == PH_MEMREQ);
        if (phase == PH_MEMREQ) begin
            check("mem_adres", anabellek_istek_adres_o, cur_adr);
            check("mem_veri", anabellek_istek_veri_o, cur_dat);
            check("mem_yaz", anabellek_istek_yaz_gecerli_o, cur_wr);
        end
        check("mem_cevap_hazir", anabellek_cevap_hazir_o, phase == PH_MEMRSP);

        exp_cg = (phase == PH_PORT) ? (cur_port ? 2'b10 : 2'b01) : 2'b00;
        check("cevap_gecerli", port_cevap_gecerli_o, exp_cg);
        if (phase == PH_PORT) begin
            check("cevap_veri", port_cevap_veri_o, exp_dlv);
            // Grant cycle counts as the first; zero-wait memory lands in the fourth.
            if (first_dlv && lat_chk) check("okuma_gecikme", cyc - grant_cyc + 1, 4);
            first_dlv = 1'b0;
        end

        case (phase)
            PH_IDLE: begin
                if (exp_hz != 2'b00) begin
                    cur_port    = w;
                    cur_adr     = req_adr[w];
                    cur_dat     = req_dat[w];
                    cur_wr      = req_wr[w];
                    req_pend[w] = 1'b0;
                    last_win    = w;
                    grant_cyc   = cyc;
                    model_grants++;
                    if (cur_wr) ref_mem[cur_adr] = cur_dat;
                    else exp_q.push_back(ref_rd(cur_adr));
                    phase = PH_MEMREQ;
                end
            end
            PH_MEMREQ: begin
                if (anabellek_istek_hazir_i) begin
                    if (anabellek_istek_yaz_gecerli_o) mem_dev[anabellek_istek_adres_o] = anabellek_istek_veri_o;
                    else dev_rd_adr = anabellek_istek_adres_o;
                    if (cur_wr) begin
                        phase = PH_IDLE;
                    end else begin
                        phase    = PH_MEMRSP;
                        resp_dly = $urandom_range(dly_min, dly_max);
                    end
                end
            end
            PH_MEMRSP: begin
                if (anabellek_cevap_gecerli_i) begin
                    phase     = PH_PORT;
                    first_dlv = 1'b1;
                    exp_dlv   = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                end
            end
            PH_PORT: begin
                if (port_cevap_hazir_i[cur_port]) begin
                    last_rsp_dat = port_cevap_veri_o;
                    last_rsp_cg  = port_cevap_gecerli_o;
                    phase        = PH_IDLE;
                end
            end
            default: phase = PH_IDLE;
        endcase
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            @(negedge clk_i);
            observe();
            cyc++;
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic run_until(input int ph, input int budget);
        int k;
        k = 0;
        while (phase != ph && k < budget) begin
            run_cycles(1);
            k++;
        end
        check("bekleme_suresi", phase == ph, 1'b1);
    endtask

    task automatic zero_check();
        check("rst_istek_hazir", port_istek_hazir_o, 2'b00);
        check("rst_cevap_gecerli", port_cevap_gecerli_o, 2'b00);
        check("rst_cevap_veri", port_cevap_veri_o, '0);
        check("rst_mem_gecerli", anabellek_istek_gecerli_o, 1'b0);
        check("rst_mem_yaz", anabellek_istek_yaz_gecerli_o, 1'b0);
        check("rst_mem_adres", anabellek_istek_adres_o, '0);
        check("rst_mem_veri", anabellek_istek_veri_o, '0);
        check("rst_mem_cevap_hazir", anabellek_cevap_hazir_o, 1'b0);
    endtask

    // Asserts reset mid-cycle (asynchronous), with every input active.
    task automatic do_reset(input int n);
        rst_i                     = 1'b1;
        port_istek_gecerli_i      = 2'b11;
        port_cevap_hazir_i        = 2'b11;
        anabellek_istek_hazir_i   = 1'b1;
        anabellek_cevap_gecerli_i = 1'b1;
        #1;
        zero_check();
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            zero_check();
            @(posedge clk_i);
            #1;
        end
        rst_i     = 1'b0;
        phase     = PH_IDLE;
        last_win  = 1'b1;
        first_dlv = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ones;
        int g0;
        rst_i = 1'b0;
        req_pend = 2'b00;
        for (int p = 0; p < 2; p++) begin
            req_adr[p] = '0; req_dat[p] = '0; req_wr[p] = 1'b0;
        end
        port_istek_adres_i = '0; port_istek_veri_i = '0;
        port_istek_gecerli_i = '0; port_istek_yaz_i = '0; port_cevap_hazir_i = '0;
        anabellek_istek_hazir_i = 1'b0; anabellek_cevap_veri_i = '0; anabellek_cevap_gecerli_i = 1'b0;
        last_rsp_dat = '0; last_rsp_cg = '0;
        #1;
        do_reset(2);

        // Port0 reads 0x100; memory answers A5 two cycles later.
        ref_mem[32'h100] = 128'hA5;
        mem_dev[32'h100] = 128'hA5;
        set_knobs(0, 100, 100, 2, 2, 0, 0);
        post_req(0, 32'h100, '0, 1'b0);
        run_cycles(1);
        run_until(PH_IDLE, 20);
        check("a_veri", last_rsp_dat, 128'hA5);
        check("a_gecerli", last_rsp_cg, 2'b01);

        // Minimum read latency with zero-wait memory.
        set_knobs(0, 100, 100, 0, 0, 0, 0);
        lat_chk = 1'b1;
        post_req(0, 32'h80, '0, 1'b0);
        run_cycles(1);
        run_until(PH_IDLE, 20);
        lat_chk = 1'b0;

        // Both ports from reset: port0 first, then strict alternation.
        do_reset(1);
        grant_log.delete();
        req_mask = 2'b11;
        set_knobs(100, 100, 100, 0, 0, 0, 0);
        run_cycles(30);
        req_pct = 0;
        clear_reqs();
        run_until(PH_IDLE, 20);
        check("b_izin_sayisi", grant_log.size() >= 6, 1'b1);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            check("b_sira", grant_log[i], i % 2);
        end

        // Port1 write held off by memory for 3 cycles.
        set_knobs(0, 0, 100, 0, 0, 0, 0);
        post_req(1, 32'h40, 128'h1234, 1'b1);
        run_cycles(4);
        acc_pct = 100;
        run_until(PH_IDLE, 10);
        check("d_yazim", dev_rd(32'h40), 128'h1234);

        // Response stalled 5 cycles while port0 waits; port0 goes next.
        set_knobs(0, 100, 0, 0, 0, 0, 0);
        post_req(1, 32'h40, '0, 1'b0);
        run_cycles(1);
        post_req(0, 32'h30, '0, 1'b0);
        run_until(PH_PORT, 10);
        run_cycles(5);
        rdy_pct = 100;
        run_until(PH_IDLE, 5);
        check("e_okunan", last_rsp_dat, 128'h1234);
        grant_log.delete();
        run_cycles(1);
        check("e_bekleyen", (grant_log.size() == 1) ? grant_log[0] : 99, 0);
        run_until(PH_IDLE, 10);

        // Reset while waiting for read data; late response must be ignored.
        set_knobs(0, 100, 100, 20, 20, 0, 0);
        post_req(0, 32'h50, '0, 1'b0);
        run_cycles(1);
        run_until(PH_MEMRSP, 10);
        run_cycles(2);
        post_req(0, 32'h60, '0, 1'b0);
        post_req(1, 32'h70, '0, 1'b0);
        do_reset(2);
        grant_log.delete();
        set_knobs(0, 0, 100, 0, 0, 100, 0);
        run_cycles(3);
        check("f_ilk_izin", (grant_log.size() >= 1) ? grant_log[0] : 99, 0);
        set_knobs(0, 100, 100, 0, 0, 0, 0);
        run_until(PH_IDLE, 10);
        run_cycles(1);
        run_until(PH_IDLE, 10);
        clear_reqs();

        // Port0 alone, requesting continuously.
        req_mask = 2'b01;
        set_knobs(100, 100, 100, 0, 0, 0, 0);
        g0 = model_grants;
        grant_log.delete();
        run_cycles(40);
        ones = 0;
        foreach (grant_log[i]) ones += grant_log[i];
        check("g_izin_sayisi", grant_log.size(), model_grants - g0);
        check("g_aclik", grant_log.size() >= 10, 1'b1);
        check("g_port1_yok", ones, 0);
        req_pct = 0;
        clear_reqs();
        run_until(PH_IDLE, 20);

        // Randomized soak with one reset in the middle.
        req_mask = 2'b11;
        set_knobs(40, 60, 60, 0, 4, 20, 5);
        run_cycles(1200);
        do_reset(1);
        run_cycles(1200);

        // Drain.
        clear_reqs();
        set_knobs(0, 100, 100, 0, 0, 0, 0);
        run_until(PH_IDLE, 100);
        run_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
